// File: rtl/i2c_reg_reader_if.sv
// i2c_reg_reader_if: request/result and I2C-controller signals of the register burst reader.
//   master modport: the reader (takes requests, drives the controller, reports bytes)
//   slave modport : the requester/controller side (drives start/params, ready, data_out)
interface i2c_reg_reader_if;
    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] base_reg;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] rd_index;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data_in;
    logic       i2c_rw;
    logic       i2c_enable;
    logic [7:0] i2c_data_out;
    logic       i2c_ready;

    modport master (
        input  start, dev_addr, base_reg, count, i2c_data_out, i2c_ready,
        output busy, done, timeout_err, rd_valid, rd_data, rd_index,
               i2c_addr, i2c_data_in, i2c_rw, i2c_enable
    );

    modport slave (
        output start, dev_addr, base_reg, count, i2c_data_out, i2c_ready,
        input  busy, done, timeout_err, rd_valid, rd_data, rd_index,
               i2c_addr, i2c_data_in, i2c_rw, i2c_enable
    );
endinterface

// File: rtl/i2c_reg_reader.sv
// i2c_reg_reader: reads a burst of consecutive registers from an I2C slave via a byte-level controller.
//   clk, rst_n : clock, async active-low reset
//   bus        : i2c_reg_reader_if.master -- start/dev_addr/base_reg/count request, busy/done/
//                timeout_err status, rd_valid/rd_data/rd_index results, i2c_* controller handshake
module i2c_reg_reader #(
    parameter int MAX_COUNT = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_reg_reader_if.master   bus
);
    localparam int         CW   = $clog2(TIMEOUT + 1);
    localparam logic [4:0] MAXC = 5'(MAX_COUNT);

    typedef enum logic [3:0] {
        IDLE, PTR_REQ, PTR_ACC, PTR_DONE, RD_REQ, RD_ACC, RD_DONE, EMIT, FIN
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sync;
    logic            rdy_s;
    logic [CW-1:0]   tcnt, tcnt_n;
    logic [6:0]      dev, dev_n;
    logic [7:0]      base, base_n;
    logic [4:0]      len, len_n;
    logic [4:0]      idx, idx_n;
    logic [7:0]      byte_q, byte_n;
    logic [4:0]      req_len;
    logic [7:0]      reg_idx;
    logic            waiting, tmo;
    logic            busy_n, done_n, te_n, rv_n, rw_n, en_n;
    logic [7:0]      rdd_n, rdi_n, din_n;
    logic [6:0]      addr_n;

    assign rdy_s   = sync[1];
    assign req_len = (bus.count > MAXC) ? MAXC : bus.count;
    assign reg_idx = base + 8'(idx);
    assign waiting = state inside {PTR_REQ, PTR_ACC, PTR_DONE, RD_REQ, RD_ACC, RD_DONE};
    assign tmo     = waiting && (tcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sync            <= '0;
            tcnt            <= '0;
            dev             <= '0;
            base            <= '0;
            len             <= '0;
            idx             <= '0;
            byte_q          <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.rd_valid    <= 1'b0;
            bus.rd_data     <= '0;
            bus.rd_index    <= '0;
            bus.i2c_addr    <= '0;
            bus.i2c_data_in <= '0;
            bus.i2c_rw      <= 1'b0;
            bus.i2c_enable  <= 1'b0;
        end else begin
            state           <= state_n;
            sync            <= {sync[0], bus.i2c_ready};
            tcnt            <= tcnt_n;
            dev             <= dev_n;
            base            <= base_n;
            len             <= len_n;
            idx             <= idx_n;
            byte_q          <= byte_n;
            bus.busy        <= busy_n;
            bus.done        <= done_n;
            bus.timeout_err <= te_n;
            bus.rd_valid    <= rv_n;
            bus.rd_data     <= rdd_n;
            bus.rd_index    <= rdi_n;
            bus.i2c_addr    <= addr_n;
            bus.i2c_data_in <= din_n;
            bus.i2c_rw      <= rw_n;
            bus.i2c_enable  <= en_n;
        end
    end

    always_comb begin
        state_n = state;
        dev_n   = dev;
        base_n  = base;
        len_n   = len;
        idx_n   = idx;
        byte_n  = byte_q;
        busy_n  = bus.busy;
        done_n  = 1'b0;
        te_n    = 1'b0;
        rv_n    = 1'b0;
        rdd_n   = bus.rd_data;
        rdi_n   = bus.rd_index;
        addr_n  = bus.i2c_addr;
        din_n   = bus.i2c_data_in;
        rw_n    = bus.i2c_rw;
        en_n    = bus.i2c_enable;
        if (tmo) begin
            state_n = IDLE;
            done_n  = 1'b1;
            te_n    = 1'b1;
            en_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    dev_n   = bus.dev_addr;
                    base_n  = bus.base_reg;
                    len_n   = req_len;
                    idx_n   = '0;
                    busy_n  = 1'b1;
                    state_n = (req_len == 5'd0) ? FIN : PTR_REQ;
                end
                // pointer write and data read share the request/accept steps; only rw differs
                PTR_REQ, RD_REQ: if (rdy_s) begin
                    addr_n  = dev;
                    rw_n    = (state == RD_REQ);
                    din_n   = reg_idx;
                    en_n    = 1'b1;
                    state_n = (state == RD_REQ) ? RD_ACC : PTR_ACC;
                end
                // controller signals acceptance by dropping ready
                PTR_ACC, RD_ACC: if (!rdy_s) begin
                    en_n    = 1'b0;
                    state_n = (state == RD_ACC) ? RD_DONE : PTR_DONE;
                end
                PTR_DONE: if (rdy_s) state_n = RD_REQ;
                RD_DONE: if (rdy_s) begin
                    byte_n  = bus.i2c_data_out;
                    state_n = EMIT;
                end
                EMIT: begin
                    rv_n    = 1'b1;
                    rdd_n   = byte_q;
                    rdi_n   = reg_idx;
                    idx_n   = idx + 5'd1;
                    state_n = (idx + 5'd1 == len) ? FIN : PTR_REQ;
                end
                FIN: begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        // restarts on every state change, idles at zero outside the wait states
        tcnt_n = (waiting && state_n == state) ? tcnt + CW'(1) : '0;
    end
endmodule

// File: tb/tb_i2c_reg_reader.sv
// tb_i2c_reg_reader: directed bench for i2c_reg_reader with a controller model and rd/ptr scoreboards.
module tb_i2c_reg_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stuck = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rv_cnt = 0;
    int   done_cnt = 0;
    int   en_cnt = 0;
    int   en_rise = 0;
    int   n_rd = 0;
    logic prev_en = 1'b0;
    logic m_busy;
    int   cd;
    logic [7:0] ptr;
    logic [6:0] exp_dev;
    logic [7:0]  exp_ptr[$];
    logic [15:0] exp_rd[$];

    i2c_reg_reader_if bus();

    i2c_reg_reader #(.MAX_COUNT(16), .TIMEOUT(100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [7:0] r);
        return r == 8'h3B ? 8'hA1 : r == 8'h3C ? 8'hB2 : r == 8'h3D ? 8'hC3 : r ^ 8'h5A;
    endfunction

    // controller model: accepts on enable, holds ready low a few cycles, returns after enable drops
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i2c_ready    <= 1'b1;
            bus.i2c_data_out <= '0;
            m_busy           <= 1'b0;
            cd               <= 0;
            ptr              <= '0;
        end else if (!m_busy) begin
            if (bus.i2c_enable && !stuck) begin
                m_busy        <= 1'b1;
                bus.i2c_ready <= 1'b0;
                cd            <= 3;
                chk("i2c_addr", bus.i2c_addr, exp_dev);
                if (!bus.i2c_rw) begin
                    chk("ptr_expected", exp_ptr.size() != 0, 1);
                    if (exp_ptr.size() != 0) begin
                        chk("ptr_wr", bus.i2c_data_in, exp_ptr[0]);
                        void'(exp_ptr.pop_front());
                    end
                    ptr <= bus.i2c_data_in;
                end else begin
                    bus.i2c_data_out <= mem(ptr);
                    n_rd <= n_rd + 1;
                end
            end
        end else if (cd != 0) begin
            cd <= cd - 1;
        end else if (!bus.i2c_enable) begin
            bus.i2c_ready <= 1'b1;
            m_busy        <= 1'b0;
        end
    end

    // output monitor: pops the read scoreboard on every rd_valid pulse
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            rv_cnt <= rv_cnt + 1;
            chk("rd_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) begin
                chk("rd_index", bus.rd_index, exp_rd[0][15:8]);
                chk("rd_data", bus.rd_data, exp_rd[0][7:0]);
                void'(exp_rd.pop_front());
            end
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.i2c_enable) en_cnt <= en_cnt + 1;
        if (bus.i2c_enable && !prev_en) en_rise <= cyc;
        prev_en <= bus.i2c_enable;
    end

    task automatic pulse_start(input logic [6:0] d, input logic [7:0] b, input logic [4:0] n);
        @(negedge clk);
        bus.start = 1'b1; bus.dev_addr = d; bus.base_reg = b; bus.count = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic burst(input logic [6:0] d, input logic [7:0] b, input logic [4:0] n);
        int m;
        logic [7:0] r;
        m = (n > 16) ? 16 : int'(n);
        exp_dev = d;
        for (int k = 0; k < m; k++) begin
            r = b + 8'(k);
            exp_ptr.push_back(r);
            exp_rd.push_back({r, mem(r)});
        end
        pulse_start(d, b, n);
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (bus.done !== 1'b1 && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", bus.done, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_te"}, bus.timeout_err, 0);
        chk({tag, "_rv"}, bus.rd_valid, 0);
        chk({tag, "_rd_data"}, bus.rd_data, 0);
        chk({tag, "_rd_index"}, bus.rd_index, 0);
        chk({tag, "_en"}, bus.i2c_enable, 0);
        chk({tag, "_rw"}, bus.i2c_rw, 0);
        chk({tag, "_addr"}, bus.i2c_addr, 0);
        chk({tag, "_din"}, bus.i2c_data_in, 0);
    endtask

    initial begin
        int snap_done, snap_rv, snap_en, t;
        bus.start = 1'b0; bus.dev_addr = '0; bus.base_reg = '0; bus.count = '0;
        exp_dev = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic burst, with a conflicting start issued mid-burst
        snap_done = done_cnt; snap_rv = rv_cnt;
        burst(7'h68, 8'h3B, 5'd3);
        repeat (5) @(negedge clk);
        pulse_start(7'h11, 8'h80, 5'd5);
        wait_done(500);
        chk("a_te", bus.timeout_err, 0);
        chk("a_busy_end", bus.busy, 0);
        @(negedge clk);
        chk("a_done_cnt", done_cnt - snap_done, 1);
        chk("a_rv_cnt", rv_cnt - snap_rv, 3);
        chk("a_rd_q_empty", exp_rd.size(), 0);
        chk("a_ptr_q_empty", exp_ptr.size(), 0);
        repeat (3) @(negedge clk);
        chk("a_ignored_start", bus.busy, 0);

        // index wrap 0xFE, 0xFF, 0x00
        burst(7'h50, 8'hFE, 5'd3);
        wait_done(500);
        @(negedge clk);
        chk("wrap_rd_q_empty", exp_rd.size(), 0);

        // count = 0: done two cycles after start, no bus activity
        snap_en = en_cnt; snap_rv = rv_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.dev_addr = 7'h20; bus.base_reg = 8'h10; bus.count = 5'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("z_done_early", bus.done, 0);
        chk("z_busy", bus.busy, 1);
        @(negedge clk);
        chk("z_done", bus.done, 1);
        chk("z_busy_end", bus.busy, 0);
        chk("z_te", bus.timeout_err, 0);
        @(negedge clk);
        chk("z_no_enable", en_cnt - snap_en, 0);
        chk("z_no_rv", rv_cnt - snap_rv, 0);

        // count above MAX_COUNT is clamped
        snap_rv = rv_cnt;
        burst(7'h33, 8'h80, 5'd20);
        wait_done(3000);
        @(negedge clk);
        chk("clamp_rv_cnt", rv_cnt - snap_rv, 16);
        chk("clamp_rd_q_empty", exp_rd.size(), 0);

        // reset during RD_DONE of byte 2
        snap_done = done_cnt;
        t = n_rd;
        burst(7'h2A, 8'h10, 5'd3);
        while (n_rd < t + 2 && cyc < 90000) @(negedge clk);
        chk("mid_second_read", n_rd - t, 2);
        while (bus.i2c_enable && cyc < 90000) @(negedge clk);
        chk("mid_rw_before", bus.i2c_rw, 1);
        #1 rst_n = 1'b0;
        #1 chk_reset("mid");
        exp_rd.delete();
        exp_ptr.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_no_done", done_cnt - snap_done, 0);
        chk("mid_idle", bus.busy, 0);
        snap_rv = rv_cnt;
        burst(7'h2A, 8'h10, 5'd3);
        wait_done(500);
        @(negedge clk);
        chk("post_rv_cnt", rv_cnt - snap_rv, 3);
        chk("post_rd_q_empty", exp_rd.size(), 0);

        // timeout: controller never drops ready
        stuck = 1'b1;
        snap_rv = rv_cnt;
        exp_dev = 7'h44;
        pulse_start(7'h44, 8'h00, 5'd2);
        t = 0;
        while (!bus.i2c_enable && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("to_enable", bus.i2c_enable, 1);
        wait_done(200);
        chk("to_te", bus.timeout_err, 1);
        chk("to_en_low", bus.i2c_enable, 0);
        chk("to_busy", bus.busy, 0);
        chk("to_latency", cyc - en_rise, 100);
        @(negedge clk);
        chk("to_te_pulse", bus.timeout_err, 0);
        chk("to_no_rv", rv_cnt - snap_rv, 0);
        stuck = 1'b0;
        exp_ptr.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_reg_reader.md
I2C_REG_READER -- requirements
Module: i2c_reg_reader

Interface
REQ-001 SHALL: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
REQ-002 SHALL: parameter MAX_COUNT, default 16, largest burst length accepted.
REQ-003 SHALL: parameter TIMEOUT, default 65535, clk cycles allowed in any wait state before abort.
REQ-004 SHALL: ports as follows (clock and reset first).
- clk  in  1  system clock, same clock as the I2C controller
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle request to begin a burst
- dev_addr  in  7  I2C slave address, latched on start
- base_reg  in  8  first register index, latched on start
- count  in  5  number of registers to read (0..MAX_COUNT), latched on start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end (normal or aborted)
- timeout_err  out  1  one-cycle pulse, coincident with done, when a burst aborts
- rd_valid  out  1  one-cycle pulse per byte read
- rd_data  out  8  byte read; valid while rd_valid=1
- rd_index  out  8  register index of rd_data
- i2c_addr  out  7  to controller addr
- i2c_data_in  out  8  to controller data_in
- i2c_rw  out  1  to controller rw: 0=write, 1=read
- i2c_enable  out  1  to controller enable
- i2c_data_out  in  8  from controller data_out
- i2c_ready  in  1  from controller ready

Function
REQ-005 SHALL: pass i2c_ready through a 2-flop synchroniser (rdy_s); all decisions use rdy_s.
REQ-006 SHALL: implement states IDLE, PTR_REQ, PTR_ACC, PTR_DONE, RD_REQ, RD_ACC, RD_DONE, EMIT, FIN.
REQ-007 SHALL: in IDLE, start=1 latches dev_addr/base_reg/count, clears byte index i, sets busy next cycle; if count=0 go to FIN directly, else go to PTR_REQ.
REQ-008 SHALL: ignore start while busy=1.
REQ-009 SHALL: treat count>MAX_COUNT as MAX_COUNT.
REQ-010 SHALL: PTR_REQ waits for rdy_s=1, then drives i2c_addr=dev_addr, i2c_rw=0, i2c_data_in=(base_reg+i) mod 256, i2c_enable=1, and goes to PTR_ACC.
REQ-011 SHALL: PTR_ACC holds i2c_enable=1 until rdy_s=0 (accepted), then drops i2c_enable and goes to PTR_DONE.
REQ-012 SHALL: PTR_DONE waits for rdy_s=1 (transaction finished), then goes to RD_REQ.
REQ-013 SHALL: RD_REQ, RD_ACC and RD_DONE mirror PTR_REQ, PTR_ACC and PTR_DONE with i2c_rw=1; on rdy_s=1 in RD_DONE, capture i2c_data_out and go to EMIT.
REQ-014 SHALL: EMIT asserts rd_valid for exactly one cycle with rd_data=captured byte and rd_index=(base_reg+i) mod 256, then increments i; if i+1=count go to FIN, else go to PTR_REQ.
REQ-015 SHALL: register index wraps 0xFF->0x00 with no error.
REQ-016 SHALL: FIN pulses done for one cycle, clears busy, returns to IDLE; a start arriving in FIN is ignored.
REQ-017 SHALL: a per-state counter clears on every state entry and runs in PTR_REQ/PTR_ACC/PTR_DONE/RD_REQ/RD_ACC/RD_DONE; reaching TIMEOUT forces i2c_enable=0, asserts timeout_err with done in the same cycle, clears busy, and returns to IDLE with no further rd_valid.
REQ-018 SHALL: i2c_enable never be asserted outside PTR_REQ exit through PTR_ACC, or RD_REQ exit through RD_ACC.
REQ-019 SHALL: i2c_addr, i2c_rw and i2c_data_in remain stable from enable assertion until rdy_s returns to 1.

Reset
REQ-020 SHALL: rst_n=0 immediately forces state IDLE, busy=0, done=0, timeout_err=0, rd_valid=0, rd_data=0, rd_index=0, i2c_enable=0, i2c_rw=0, i2c_addr=0, i2c_data_in=0, i=0, timeout counter=0, synchroniser=0.
REQ-021 SHALL: reset asserted mid-burst abandon the burst without a done pulse; after release the block idles until a new start.

Verification
REQ-022 SHALL: dev_addr=0x68, base_reg=0x3B, count=3, controller model returning 0xA1/0xB2/0xC3 -> three pointer writes (0x3B,0x3C,0x3D), three reads, rd_valid pulses with (0x3B,0xA1),(0x3C,0xB2),(0x3D,0xC3), then one done pulse, timeout_err=0.
REQ-023 SHALL: base_reg=0xFE, count=3 -> rd_index sequence 0xFE,0xFF,0x00.
REQ-024 SHALL: count=0 -> done pulse two cycles after start, no i2c_enable assertion, no rd_valid.
REQ-025 SHALL: controller model holds ready=1 forever after enable, TIMEOUT=100 -> i2c_enable drops, done and timeout_err pulse together 100 cycles after PTR_ACC entry, busy=0.
REQ-026 SHALL: second start during busy -> ignored, latched parameters unchanged.
REQ-027 SHALL: rst_n low during RD_DONE of byte 2 -> all outputs at reset values asynchronously, no done; a new start after release runs a full burst correctly.
